// File: rtl/bus_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_arb_pkg : shared types and sizing helpers for the round-robin arbiter  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package bus_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUS  = 1'b1
  } arb_state_e;

  // Width needed to index n items, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_rr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_rr_arbiter_if : requester-side and bus-side signals of the arbiter     |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
interface bus_rr_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_grant;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        req_error;

  logic [ADDR_W-1:0]         addr;
  logic [ID_W-1:0]           valid;
  logic [DATA_W-1:0]         data;
  logic                      wen;
  logic                      ren;
  logic                      ready;
  logic                      busy;

  modport master (
    input  req_valid, req_write, req_addr, req_data, ready,
    output req_grant, req_done, req_error, addr, valid, data, wen, ren, busy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_data, ready,
    input  req_grant, req_done, req_error, addr, valid, data, wen, ren, busy
  );

endinterface
`default_nettype wire

// File: rtl/bus_rr_arbiter_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_picker : combinational rotate-priority select, searching from ptr+1     |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] req,
  input  wire logic [ID_W-1:0]    ptr,
  output logic      [NUM_REQ-1:0] grant,
  output logic      [ID_W-1:0]    winner,
  output logic                    any
);

  always_comb begin
    int idx;
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    // The last-served requester is visited last, so it has lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[ID_W'(idx)]) begin
        any                = 1'b1;
        grant[ID_W'(idx)]  = 1'b1;
        winner             = ID_W'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_rr_arbiter : round-robin sharing of one single-outstanding bus port    |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input wire logic         clk,
  input wire logic         reset,
  bus_rr_arbiter_if.master bus
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = id_width(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wen_q, wen_d;
  logic                ren_q, ren_d;
  logic                busy_q, busy_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [NUM_REQ-1:0]  error_q, error_d;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_id;
  logic                pick_any;
  logic [NUM_REQ-1:0]  owner_onehot;

  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
      assign addr_arr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
      assign data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
    end
  endgenerate

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (bus.req_valid),
    .ptr    (ptr_q),
    .grant  (pick_grant),
    .winner (pick_id),
    .any    (pick_any)
  );

  assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wen_d   = wen_q;
    ren_d   = ren_q;
    grant_d = '0;
    done_d  = '0;
    error_d = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BUS;
          ptr_d   = pick_id;
          owner_d = pick_id;
          cnt_d   = '0;
          addr_d  = addr_arr[pick_id];
          data_d  = bus.req_write[pick_id] ? data_arr[pick_id] : '0;
          wen_d   = bus.req_write[pick_id];
          ren_d   = ~bus.req_write[pick_id];
          grant_d = pick_grant;
        end
      end
      BUS: begin
        // A ready on the last allowed cycle still wins over the timeout.
        if (bus.ready) begin
          done_d  = owner_onehot;
          wen_d   = 1'b0;
          ren_d   = 1'b0;
          state_d = IDLE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          error_d = owner_onehot;
          wen_d   = 1'b0;
          ren_d   = 1'b0;
          state_d = IDLE;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == BUS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      error_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign bus.req_grant = grant_q;
  assign bus.req_done  = done_q;
  assign bus.req_error = error_q;
  assign bus.addr      = addr_q;
  assign bus.valid     = owner_q;
  assign bus.data      = data_q;
  assign bus.wen       = wen_q;
  assign bus.ren       = ren_q;
  assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bus_rr_arbiter : directed and randomized checks of bus_rr_arbiter       |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module tb_bus_rr_arbiter;
  import bus_arb_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int TO  = 8;
  localparam int IDW = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_rr_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bif ();

  bus_rr_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: transaction-level view of who owns the bus and for how long.
  bit             m_busy;
  int             m_owner;
  int             m_last;
  int             m_bus_cycles;
  logic [N-1:0]   e_grant, e_done, e_error;
  logic [AW-1:0]  e_addr;
  logic [IDW-1:0] e_valid;
  logic [DW-1:0]  e_data;
  logic           e_wen, e_ren, e_busy;

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_last = N - 1; m_bus_cycles = 0;
    e_grant = '0; e_done = '0; e_error = '0;
    e_addr = '0; e_valid = '0; e_data = '0;
    e_wen = 1'b0; e_ren = 1'b0; e_busy = 1'b0;
  endtask

  task automatic model_step();
    e_grant = '0; e_done = '0; e_error = '0;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (bif.req_valid[c]) begin
          m_busy = 1'b1; m_owner = c; m_last = c; m_bus_cycles = 1;
          e_addr  = bif.req_addr[c*AW +: AW];
          e_data  = bif.req_write[c] ? bif.req_data[c*DW +: DW] : '0;
          e_wen   = bif.req_write[c];
          e_ren   = !bif.req_write[c];
          e_valid = IDW'(c);
          e_grant[c] = 1'b1;
          break;
        end
      end
    end else if (bif.ready) begin
      e_done[m_owner] = 1'b1; m_busy = 1'b0; e_wen = 1'b0; e_ren = 1'b0;
    end else if (m_bus_cycles == TO) begin
      e_error[m_owner] = 1'b1; m_busy = 1'b0; e_wen = 1'b0; e_ren = 1'b0;
    end else begin
      m_bus_cycles++;
    end
    e_busy = m_busy;
  endtask

  task automatic clear_inputs();
    bif.req_valid = '0; bif.req_write = '0;
    bif.req_addr  = '0; bif.req_data  = '0;
    bif.ready     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({bif.req_grant, bif.req_done, bif.req_error, bif.wen, bif.ren, bif.busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 0", {bif.req_grant, bif.req_done, bif.req_error, bif.wen, bif.ren, bif.busy});
    end
    tests_run++;
    if (bif.addr !== '0 || bif.valid !== '0 || bif.data !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: got addr=%h valid=%h data=%h expected all 0", bif.addr, bif.valid, bif.data);
    end
    bif.req_valid = '1; bif.ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({bif.req_grant, bif.wen, bif.ren, bif.busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_held: got %b expected 0", {bif.req_grant, bif.wen, bif.ren, bif.busy});
    end
    clear_inputs();
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_single_write();
    bif.ready = 1'b1;
    bif.req_valid = 4'b0001; bif.req_write = 4'b0001;
    bif.req_addr[0 +: AW] = 32'h0000_1000;
    bif.req_data[0 +: DW] = 64'hDEAD_BEEF_0000_0001;
    cycle();
    tests_run++;
    if (bif.wen !== 1'b1 || bif.ren !== 1'b0 || bif.addr !== 32'h1000 || bif.valid !== 2'd0) begin
      tests_failed++;
      $display("FAIL write_bus: got wen=%b ren=%b addr=%h valid=%0d expected 1 0 1000 0", bif.wen, bif.ren, bif.addr, bif.valid);
    end
    tests_run++;
    if (bif.req_grant !== 4'b0001 || bif.data !== 64'hDEAD_BEEF_0000_0001 || bif.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_grant: got grant=%b data=%h busy=%b expected 0001 deadbeef00000001 1", bif.req_grant, bif.data, bif.busy);
    end
    bif.req_valid = '0;
    cycle();
    tests_run++;
    if (bif.req_done !== 4'b0001 || bif.wen !== 1'b0 || bif.req_grant !== 4'b0000 || bif.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_done: got done=%b wen=%b grant=%b busy=%b expected 0001 0 0000 0", bif.req_done, bif.wen, bif.req_grant, bif.busy);
    end
  endtask

  task automatic test_all_read();
    logic [AW-1:0] a [N];
    logic [N-1:0]  exp_oh;
    int k;
    do_reset();
    bif.ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      a[i] = $urandom;
      bif.req_addr[i*AW +: AW] = a[i];
      bif.req_data[i*DW +: DW] = {$urandom, $urandom};
    end
    bif.req_valid = '1; bif.req_write = '0;
    for (int c = 1; c <= 2 * N; c++) begin
      cycle();
      k = (c - 1) / 2;
      exp_oh = N'(1) << k;
      tests_run++;
      if (c % 2 == 1) begin
        if (bif.req_grant !== exp_oh || bif.valid !== IDW'(k) || bif.ren !== 1'b1 ||
            bif.wen !== 1'b0 || bif.data !== '0 || bif.addr !== a[k]) begin
          tests_failed++;
          $display("FAIL rr_grant%0d: got grant=%b valid=%0d ren=%b wen=%b data=%h addr=%h expected %b %0d 1 0 0 %h",
                   k, bif.req_grant, bif.valid, bif.ren, bif.wen, bif.data, bif.addr, exp_oh, k, a[k]);
        end
        bif.req_valid[k] = 1'b0;
      end else begin
        if (bif.req_done !== exp_oh || bif.req_grant !== '0 || bif.ren !== 1'b0) begin
          tests_failed++;
          $display("FAIL rr_done%0d: got done=%b grant=%b ren=%b expected %b 0000 0", k, bif.req_done, bif.req_grant, bif.ren, exp_oh);
        end
      end
    end
  endtask

  task automatic test_ready_stall();
    logic [AW-1:0] a;
    a = $urandom;
    bif.ready = 1'b0;
    bif.req_write = '0;
    bif.req_addr[1*AW +: AW] = a;
    bif.req_valid = 4'b0010;
    cycle();
    tests_run++;
    if (bif.req_grant !== 4'b0010) begin
      tests_failed++;
      $display("FAIL stall_grant: got %b expected 0010", bif.req_grant);
    end
    bif.req_valid = '0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) cycle();
      tests_run++;
      if (bif.addr !== a || bif.data !== '0 || bif.valid !== 2'd1 || bif.ren !== 1'b1 ||
          bif.wen !== 1'b0 || bif.req_done !== '0) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: got addr=%h data=%h valid=%0d ren=%b wen=%b done=%b expected %h 0 1 1 0 0000",
                 c, bif.addr, bif.data, bif.valid, bif.ren, bif.wen, bif.req_done, a);
      end
    end
    bif.ready = 1'b1;
    cycle();
    tests_run++;
    if (bif.req_done !== 4'b0010 || bif.ren !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_done: got done=%b ren=%b expected 0010 0", bif.req_done, bif.ren);
    end
    cycle();
    tests_run++;
    if (bif.req_done !== '0 || bif.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_done_once: got done=%b busy=%b expected 0000 0", bif.req_done, bif.busy);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    bif.ready = 1'b0;
    bif.req_write = 4'b0100;
    bif.req_addr[2*AW +: AW] = 32'hA000_0002;
    bif.req_addr[3*AW +: AW] = 32'hA000_0003;
    bif.req_valid = 4'b1100;
    cycle();
    tests_run++;
    if (bif.req_grant !== 4'b0100 || bif.wen !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_grant: got grant=%b wen=%b expected 0100 1", bif.req_grant, bif.wen);
    end
    bif.req_valid[2] = 1'b0;
    for (int c = 2; c <= TO; c++) begin
      cycle();
      tests_run++;
      if (bif.wen !== 1'b1 || bif.req_error !== '0) begin
        tests_failed++;
        $display("FAIL to_wait%0d: got wen=%b error=%b expected 1 0000", c, bif.wen, bif.req_error);
      end
    end
    cycle();
    tests_run++;
    if (bif.req_error !== 4'b0100 || bif.wen !== 1'b0 || bif.busy !== 1'b0 || bif.req_done !== '0) begin
      tests_failed++;
      $display("FAIL to_error: got error=%b wen=%b busy=%b done=%b expected 0100 0 0 0000", bif.req_error, bif.wen, bif.busy, bif.req_done);
    end
    cycle();
    tests_run++;
    if (bif.req_grant !== 4'b1000 || bif.req_error !== '0 || bif.ren !== 1'b1) begin
      tests_failed++;
      $display("FAIL to_next_grant: got grant=%b error=%b ren=%b expected 1000 0000 1", bif.req_grant, bif.req_error, bif.ren);
    end
    bif.req_valid[3] = 1'b0;
    for (int c = 2; c <= TO; c++) begin
      cycle();
      tests_run++;
      if (bif.ren !== 1'b1 || bif.req_error !== '0) begin
        tests_failed++;
        $display("FAIL to_wait_b%0d: got ren=%b error=%b expected 1 0000", c, bif.ren, bif.req_error);
      end
    end
    bif.ready = 1'b1;
    cycle();
    tests_run++;
    if (bif.req_done !== 4'b1000 || bif.req_error !== '0) begin
      tests_failed++;
      $display("FAIL to_last_ready: got done=%b error=%b expected 1000 0000", bif.req_done, bif.req_error);
    end
  endtask

  task automatic test_async_reset();
    bif.ready = 1'b0;
    bif.req_write = '0;
    bif.req_addr[1*AW +: AW] = 32'h5555_0001;
    bif.req_valid = 4'b0010;
    cycle();
    tests_run++;
    if (bif.ren !== 1'b1 || bif.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_setup: got ren=%b busy=%b expected 1 1", bif.ren, bif.busy);
    end
    bif.req_valid = '0;
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (bif.ren !== 1'b0 || bif.busy !== 1'b0 || bif.addr !== '0 || bif.valid !== '0) begin
      tests_failed++;
      $display("FAIL areset_abort: got ren=%b busy=%b addr=%h valid=%0d expected 0 0 0 0", bif.ren, bif.busy, bif.addr, bif.valid);
    end
    bif.req_valid = '1;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    cycle();
    tests_run++;
    if (bif.req_grant !== 4'b0001 || bif.valid !== 2'd0 || bif.req_done !== '0 || bif.req_error !== '0) begin
      tests_failed++;
      $display("FAIL areset_first: got grant=%b valid=%0d done=%b error=%b expected 0001 0 0000 0000", bif.req_grant, bif.valid, bif.req_done, bif.req_error);
    end
    bif.req_valid = '0;
    bif.ready = 1'b1;
    cycle();
  endtask

  task automatic test_fairness();
    int  g0, g2, wait2;
    bit  pend2;
    g0 = 0; g2 = 0; wait2 = 0; pend2 = 1'b0;
    do_reset();
    bif.ready = 1'b1;
    bif.req_valid[0] = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      cycle();
      tests_run++;
      if ({bif.req_grant, bif.req_done, bif.req_error, bif.wen, bif.ren, bif.busy} !==
          {e_grant, e_done, e_error, e_wen, e_ren, e_busy}) begin
        tests_failed++;
        $display("FAIL fair_model c%0d: got %b expected %b", c,
                 {bif.req_grant, bif.req_done, bif.req_error, bif.wen, bif.ren, bif.busy},
                 {e_grant, e_done, e_error, e_wen, e_ren, e_busy});
      end
      if (bif.req_grant[0]) g0++;
      if (pend2) begin
        wait2++;
        if (bif.req_grant[2]) begin
          g2++;
          tests_run++;
          if (wait2 > 3) begin
            tests_failed++;
            $display("FAIL fair_latency: got %0d cycles expected <= 3", wait2);
          end
          pend2 = 1'b0;
          bif.req_valid[2] = 1'b0;
        end else if (wait2 > 6) begin
          tests_run++;
          tests_failed++;
          $display("FAIL fair_starved: got no grant after %0d cycles expected <= 3", wait2);
          pend2 = 1'b0;
          bif.req_valid[2] = 1'b0;
        end
      end
      if ((c == 13 || c == 40 || c == 77) && !pend2) begin
        bif.req_addr[2*AW +: AW] = $urandom;
        bif.req_valid[2] = 1'b1;
        pend2 = 1'b1;
        wait2 = 0;
      end
    end
    tests_run++;
    if (g2 != 3 || g0 < 45) begin
      tests_failed++;
      $display("FAIL fair_counts: got req2=%0d req0=%0d expected 3 and >=45", g2, g0);
    end
    bif.req_valid = '0;
    cycle();
    cycle();
  endtask

  task automatic test_random();
    bit pend [N];
    do_reset();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      bif.ready = (c < 200) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
      cycle();
      tests_run++;
      if ({bif.req_grant, bif.req_done, bif.req_error, bif.wen, bif.ren, bif.busy} !==
          {e_grant, e_done, e_error, e_wen, e_ren, e_busy}) begin
        tests_failed++;
        $display("FAIL rand_ctrl c%0d: got %b expected %b", c,
                 {bif.req_grant, bif.req_done, bif.req_error, bif.wen, bif.ren, bif.busy},
                 {e_grant, e_done, e_error, e_wen, e_ren, e_busy});
      end
      if (e_busy) begin
        tests_run++;
        if (bif.addr !== e_addr || bif.valid !== e_valid || bif.data !== e_data) begin
          tests_failed++;
          $display("FAIL rand_bus c%0d: got addr=%h valid=%0d data=%h expected %h %0d %h",
                   c, bif.addr, bif.valid, bif.data, e_addr, e_valid, e_data);
        end
      end
      tests_run++;
      if ((bif.wen && bif.ren) || !$onehot0(bif.req_grant) || !$onehot0(bif.req_done) || !$onehot0(bif.req_error)) begin
        tests_failed++;
        $display("FAIL rand_exclusive c%0d: got wen=%b ren=%b grant=%b done=%b error=%b expected exclusive",
                 c, bif.wen, bif.ren, bif.req_grant, bif.req_done, bif.req_error);
      end
      for (int i = 0; i < N; i++) begin
        if (pend[i] && bif.req_grant[i]) begin
          pend[i] = 1'b0;
          bif.req_valid[i] = 1'b0;
        end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          bif.req_valid[i] = 1'b1;
          bif.req_write[i] = $urandom_range(0, 1) == 1;
          bif.req_addr[i*AW +: AW] = $urandom;
          bif.req_data[i*DW +: DW] = {$urandom, $urandom};
        end
      end
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_single_write();
    test_all_read();
    test_ready_stall();
    test_timeout();
    test_async_reset();
    test_fairness();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 ns expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one single-outstanding bus master port between NUM_REQ requesters. The port is addr/valid/data/wen/ren/ready. It captures the winning request, drives the port until the slave returns ready, then reports completion or timeout to the owner. It sits between the client engines and the bus master interface.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ADDR_W, 32, address width
DATA_W, 64, write data width
TIMEOUT, 255, max bus cycles waiting for ready; 0 disables the timeout
ID_W (localparam), $clog2(NUM_REQ), requester ID width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request
req_write  in  NUM_REQ  1=write (wen), 0=read (ren)
req_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  flattened write data
req_grant  out  NUM_REQ  one-hot 1-cycle pulse: request accepted, payload captured
req_done  out  NUM_REQ  one-hot 1-cycle pulse: transfer completed
req_error  out  NUM_REQ  one-hot 1-cycle pulse: transfer aborted by timeout
addr  out  ADDR_W  bus address
valid  out  ID_W  ID of current bus owner
data  out  DATA_W  bus write data (0 for reads)
wen  out  1  write strobe
ren  out  1  read strobe
ready  in  1  slave completion
busy  out  1  high while in BUS state

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; rr pointer = NUM_REQ-1, so requester 0 has first priority; timeout counter 0.
- All outputs are registered.
- FSM states: IDLE, BUS.
- IDLE: if any req_valid, pick the winner by searching from ptr+1 upward mod NUM_REQ. Capture addr/data and ID into valid. Set wen=req_write[w] or ren=~req_write[w]. Pulse req_grant[w]. Set ptr=w and go to BUS. No request: stay in IDLE.
- Timing: request sampled at edge 0; wen/ren, addr, valid and req_grant are visible in cycle 1.
- BUS: addr/data/valid/wen/ren are held stable. req_valid is ignored for all requesters.
  - ready=1 sampled: clear wen/ren, pulse req_done[owner] next cycle, go to IDLE.
  - Minimum transfer: 2 cycles request-to-done; back-to-back transfers every 2 cycles (one IDLE arbitration cycle).
- Timeout: counter increments each BUS cycle with ready=0. If TIMEOUT cycles elapse without ready: clear wen/ren, pulse req_error[owner], go to IDLE, ptr still advances.
  - ready arriving on the final cycle counts as completion, not error.
  - Counter clears on entry to BUS.
- Requester contract: hold req_valid and payload until req_grant. Withdrawing before grant is legal. Deassert in the cycle grant is seen. req_valid high in any IDLE cycle is a new request.
- data is driven 0 on reads.
- wen and ren are never high together; both are low in IDLE.
- ready while wen=ren=0 is ignored.
- Reset mid-transfer: immediate abort; no done/error pulse.
- Grant/done/error are one-hot and never overlap in the same cycle for one requester.

Decomposition:
- Package bus_arb_pkg: state enum (IDLE, BUS), default width constants (ADDR_W=32, DATA_W=64), and a function computing ID_W.
- Sub-module rr_picker: combinational rotate-priority select.
  - Inputs: req vector and ptr. Outputs: one-hot grant, encoded winner, any.
  - Verified standalone; the arbiter instantiates it once.

Test Plan:
- req_valid[0] write, addr 0x1000, data 0xDEADBEEF00000001, ready tied 1 -> cycle 1: wen=1, addr=0x1000, valid=0, req_grant=0001; cycle 2: req_done=0001, wen=0.
- All 4 requesters read simultaneously and hold until grant, ready=1 -> grants in order 0,1,2,3, one every 2 cycles; valid=0,1,2,3; ren only, data=0.
- ready held 0 for 3 BUS cycles -> addr/data/valid/ren unchanged all 3 cycles; req_done exactly 1 cycle after ready=1.
- TIMEOUT=8, ready stuck 0 -> after 8 BUS cycles wen drops and req_error[owner] pulses once; next pending requester granted 2 cycles later.
- reset=0 asynchronously mid-BUS with ren=1 -> ren, busy, addr and valid go 0 before the next edge; after release, with all requests high, requester 0 wins first.
- req0 continuously requesting, req2 pulses one request -> req2 granted no later than after one req0 transfer; no starvation over 100 cycles.
